// File: rtl/axil_sdram_arb.sv
// Round-robin arbiter funnelling NPORTS AXI-lite slave ports onto one SDRAM request channel.
// Reads complete in order; a tag FIFO steers each returned word back to the issuing port.
module axil_sdram_arb #(
  parameter int unsigned NPORTS       = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SDADDR_WIDTH = 24,
  parameter int unsigned MAX_RD       = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NPORTS*ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [NPORTS-1:0]              s_awvalid,
  output logic [NPORTS-1:0]              s_awready,
  input  logic [NPORTS*DATA_WIDTH-1:0]   s_wdata,
  input  logic [NPORTS*DATA_WIDTH/8-1:0] s_wstrb,
  input  logic [NPORTS-1:0]              s_wvalid,
  output logic [NPORTS-1:0]              s_wready,
  output logic [NPORTS*2-1:0]            s_bresp,
  output logic [NPORTS-1:0]              s_bvalid,
  input  logic [NPORTS-1:0]              s_bready,
  input  logic [NPORTS*ADDR_WIDTH-1:0]   s_araddr,
  input  logic [NPORTS-1:0]              s_arvalid,
  output logic [NPORTS-1:0]              s_arready,
  output logic [NPORTS*DATA_WIDTH-1:0]   s_rdata,
  output logic [NPORTS*2-1:0]            s_rresp,
  output logic [NPORTS-1:0]              s_rvalid,
  input  logic [NPORTS-1:0]              s_rready,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic                           req_we,
  output logic [SDADDR_WIDTH-1:0]        req_addr,
  output logic [DATA_WIDTH-1:0]          req_wdata,
  output logic [DATA_WIDTH/8-1:0]        req_wmask,
  input  logic                           rsp_valid,
  input  logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           err_unexp
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned TW = $clog2(MAX_RD);
  localparam int unsigned CW = TW + 1;

  logic [NPORTS-1:0]            r_bvalid, r_rvalid, r_rd_pend, r_pref_rd;
  logic [NPORTS*2-1:0]          r_bresp, r_rresp;
  logic [NPORTS*DATA_WIDTH-1:0] r_rdata;
  logic [PW-1:0]                r_ptr;
  logic                         r_req_valid, r_req_we;
  logic [SDADDR_WIDTH-1:0]      r_req_addr;
  logic [DATA_WIDTH-1:0]        r_req_wdata;
  logic [SW-1:0]                r_req_wmask;
  logic [PW-1:0]                r_tags [MAX_RD];
  logic [TW-1:0]                r_wp, r_rp;
  logic [CW-1:0]                r_cnt;
  logic                         r_err;

  logic [NPORTS-1:0]     w_busy, w_elig_w, w_elig_r;
  logic                  w_slot_free, w_gnt, w_gnt_we, w_gnt_oor;
  logic [PW-1:0]         w_gnt_idx, w_j;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_wdata;
  logic [SW-1:0]         w_gnt_wstrb;
  logic                  w_push, w_pop;
  logic [PW-1:0]         w_pop_tag;

  // Gating the slot with rst_n keeps every ready low while reset is held.
  assign w_slot_free = rst_n & (~r_req_valid | req_ready);

  always_comb begin
    for (int p = 0; p < int'(NPORTS); p++) begin
      w_busy[p]   = r_bvalid[p] | r_rvalid[p] | r_rd_pend[p];
      w_elig_w[p] = s_awvalid[p] & s_wvalid[p] & ~w_busy[p];
      w_elig_r[p] = s_arvalid[p] & ~w_busy[p] & (r_cnt < CW'(MAX_RD));
    end
  end

  // Scan from the pointer; iterating downward lets the nearest eligible port win.
  always_comb begin
    int j;
    j         = 0;
    w_j       = '0;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= int'(NPORTS)) j = j - int'(NPORTS);
      w_j = PW'(j);
      if (w_slot_free && (w_elig_w[w_j] || w_elig_r[w_j])) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_j;
      end
    end
  end

  assign w_gnt_we = w_elig_w[w_gnt_idx] & (~w_elig_r[w_gnt_idx] | ~r_pref_rd[w_gnt_idx]);

  always_comb begin
    w_gnt_addr  = '0;
    w_gnt_wdata = '0;
    w_gnt_wstrb = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      s_awready[p] = w_gnt & w_gnt_we & (w_gnt_idx == PW'(p));
      s_wready[p]  = w_gnt & w_gnt_we & (w_gnt_idx == PW'(p));
      s_arready[p] = w_gnt & ~w_gnt_we & (w_gnt_idx == PW'(p));
      if (w_gnt_idx == PW'(p)) begin
        w_gnt_addr  = w_gnt_we ? s_awaddr[p*ADDR_WIDTH +: ADDR_WIDTH]
                               : s_araddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_gnt_wdata = s_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        w_gnt_wstrb = s_wstrb[p*SW +: SW];
      end
    end
  end

  assign w_gnt_oor = (w_gnt_addr >> (SDADDR_WIDTH + 2)) != '0;
  assign w_push    = w_gnt & ~w_gnt_we & ~w_gnt_oor;
  assign w_pop     = rsp_valid & (r_cnt != '0);
  assign w_pop_tag = r_tags[r_rp];

  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wp] <= w_gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid    <= '0;
      r_rvalid    <= '0;
      r_rd_pend   <= '0;
      r_pref_rd   <= '0;
      r_bresp     <= '0;
      r_rresp     <= '0;
      r_rdata     <= '0;
      r_ptr       <= '0;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wmask <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_ptr <= (w_gnt_idx == PW'(NPORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_pref_rd[w_gnt_idx] <= w_gnt_we;
      end

      if (w_gnt && !w_gnt_oor) begin
        r_req_valid <= 1'b1;
        r_req_we    <= w_gnt_we;
        r_req_addr  <= SDADDR_WIDTH'(w_gnt_addr >> 2);
        r_req_wdata <= w_gnt_we ? w_gnt_wdata : '0;
        r_req_wmask <= w_gnt_we ? w_gnt_wstrb : '0;
      end else if (req_ready) begin
        r_req_valid <= 1'b0;
      end

      for (int p = 0; p < int'(NPORTS); p++) begin
        if (r_bvalid[p] && s_bready[p]) r_bvalid[p] <= 1'b0;
        if (r_rvalid[p] && s_rready[p]) r_rvalid[p] <= 1'b0;
        if (w_gnt && (w_gnt_idx == PW'(p))) begin
          if (w_gnt_we) begin
            r_bvalid[p]        <= 1'b1;
            r_bresp[2*p +: 2]  <= w_gnt_oor ? 2'b10 : 2'b00;
          end else if (w_gnt_oor) begin
            r_rvalid[p]                     <= 1'b1;
            r_rresp[2*p +: 2]               <= 2'b10;
            r_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= '0;
          end else begin
            r_rd_pend[p] <= 1'b1;
          end
        end
        if (w_pop && (w_pop_tag == PW'(p))) begin
          r_rd_pend[p]                        <= 1'b0;
          r_rvalid[p]                         <= 1'b1;
          r_rresp[2*p +: 2]                   <= 2'b00;
          r_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= rsp_rdata;
        end
      end

      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      if (rsp_valid && (r_cnt == '0)) r_err <= 1'b1;
    end
  end

  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;
  assign req_valid = r_req_valid;
  assign req_we    = r_req_we;
  assign req_addr  = r_req_addr;
  assign req_wdata = r_req_wdata;
  assign req_wmask = r_req_wmask;
  assign err_unexp = r_err;

endmodule

// File: tb/tb_axil_sdram_arb.sv
// Directed bench for axil_sdram_arb with four ports; expected values are hand-derived per cycle.
module tb_axil_sdram_arb;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SA = 24;

  logic              clk, rst_n;
  logic [NP*AW-1:0]  s_awaddr, s_araddr;
  logic [NP-1:0]     s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic [NP*DW-1:0]  s_wdata;
  logic [NP*DW/8-1:0] s_wstrb;
  logic [NP-1:0]     s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [NP*2-1:0]   s_bresp, s_rresp;
  logic [NP*DW-1:0]  s_rdata;
  logic              req_valid, req_ready, req_we;
  logic [SA-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_wmask;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              err_unexp;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle vector tables
  logic [3:0]  tv_awv [16];
  logic [3:0]  tv_arv [16];
  logic        tv_rspv[16];
  logic [31:0] tv_rspd[16];
  logic [3:0]  ex_aw  [16];
  logic [3:0]  ex_ar  [16];
  logic [3:0]  ex_rv  [16];
  logic [31:0] ex_rd  [16];
  logic        ex_ac  [16];
  logic [23:0] ex_addr[16];

  axil_sdram_arb #(
    .NPORTS      (NP),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .SDADDR_WIDTH(SA),
    .MAX_RD      (4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_awaddr (s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bresp  (s_bresp),
    .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .s_araddr (s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .err_unexp(err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    s_awaddr[p*AW +: AW] = a;
    s_wdata[p*DW +: DW]  = d;
    s_wstrb[p*4 +: 4]    = s;
  endtask

  task automatic set_ar(input int p, input logic [31:0] a);
    s_araddr[p*AW +: AW] = a;
  endtask

  task automatic clear_tv();
    for (int c = 0; c < 16; c++) begin
      tv_awv[c] = '0; tv_arv[c] = '0; tv_rspv[c] = 1'b0; tv_rspd[c] = '0;
      ex_aw[c] = '0; ex_ar[c] = '0; ex_rv[c] = '0; ex_rd[c] = '0;
      ex_ac[c] = 1'b0; ex_addr[c] = '0;
    end
  endtask

  task automatic run_tv(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      s_awvalid = tv_awv[c];
      s_wvalid  = tv_awv[c];
      s_arvalid = tv_arv[c];
      rsp_valid = tv_rspv[c];
      rsp_rdata = tv_rspd[c];
      @(negedge clk);
      check($sformatf("%s_awready_c%0d", name, c), 64'(s_awready), 64'(ex_aw[c]));
      check($sformatf("%s_arready_c%0d", name, c), 64'(s_arready), 64'(ex_ar[c]));
      check($sformatf("%s_rvalid_c%0d", name, c), 64'(s_rvalid), 64'(ex_rv[c]));
      for (int p = 0; p < NP; p++) begin
        if (ex_rv[c][p]) begin
          check($sformatf("%s_rdata%0d_c%0d", name, p, c), 64'(s_rdata[p*DW +: DW]),
                64'(ex_rd[c]));
          check($sformatf("%s_rresp%0d_c%0d", name, p, c), 64'(s_rresp[p*2 +: 2]), 64'd0);
        end
      end
      if (ex_ac[c]) begin
        check($sformatf("%s_req_valid_c%0d", name, c), 64'(req_valid), 64'd1);
        check($sformatf("%s_req_addr_c%0d", name, c), 64'(req_addr), 64'(ex_addr[c]));
      end
      next_cyc();
    end
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; rsp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_awvalid = 4'b0001; s_wvalid = 4'b0001; s_arvalid = 4'b0010;
    s_bready = 4'hF; s_rready = 4'hF; req_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0;

    // Reset: readies gated even with valids high
    next_cyc();
    @(negedge clk);
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_err", 64'(err_unexp), 64'd0);
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    next_cyc();
    rst_n = 1'b1;

    // Single write on port 0
    set_wr(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    s_awvalid = 4'b0001; s_wvalid = 4'b0001;
    @(negedge clk);
    check("wr_awready", 64'(s_awready), 64'b0001);
    check("wr_wready", 64'(s_wready), 64'b0001);
    check("wr_arready", 64'(s_arready), 64'd0);
    next_cyc();
    s_awvalid = '0; s_wvalid = '0;
    @(negedge clk);
    check("wr_req_valid", 64'(req_valid), 64'd1);
    check("wr_req_we", 64'(req_we), 64'd1);
    check("wr_req_addr", 64'(req_addr), 64'h4);
    check("wr_req_wdata", 64'(req_wdata), 64'hDEAD_BEEF);
    check("wr_req_wmask", 64'(req_wmask), 64'hF);
    check("wr_bvalid", 64'(s_bvalid), 64'b0001);
    check("wr_bresp", 64'(s_bresp[1:0]), 64'd0);
    check("wr_awready_drop", 64'(s_awready), 64'd0);
    next_cyc();
    @(negedge clk);
    check("wr_req_clear", 64'(req_valid), 64'd0);
    check("wr_b_clear", 64'(s_bvalid), 64'd0);
    next_cyc();

    // Backpressure: port 1 write held with req_ready low, port 2 waiting
    set_wr(1, 32'h0000_0020, 32'h1234_5678, 4'h3);
    set_wr(2, 32'h0000_0040, 32'hCAFE_F00D, 4'hC);
    req_ready = 1'b0;
    s_awvalid = 4'b0010; s_wvalid = 4'b0010;
    @(negedge clk);
    check("bp_awready", 64'(s_awready), 64'b0010);
    next_cyc();
    s_awvalid = 4'b0100; s_wvalid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), 64'(req_valid), 64'd1);
      check($sformatf("bp_addr_%0d", k), 64'(req_addr), 64'h8);
      check($sformatf("bp_wdata_%0d", k), 64'(req_wdata), 64'h1234_5678);
      check($sformatf("bp_wmask_%0d", k), 64'(req_wmask), 64'h3);
      check($sformatf("bp_nogrant_%0d", k), 64'(s_awready), 64'd0);
      next_cyc();
    end
    req_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 64'(s_awready), 64'b0100);
    check("bp_release_addr", 64'(req_addr), 64'h8);
    next_cyc();
    s_awvalid = '0; s_wvalid = '0;
    @(negedge clk);
    check("bp2_addr", 64'(req_addr), 64'h10);
    check("bp2_wdata", 64'(req_wdata), 64'hCAFE_F00D);
    check("bp2_wmask", 64'(req_wmask), 64'hC);
    check("bp2_bvalid", 64'(s_bvalid), 64'b0100);
    next_cyc();
    rsp_valid = 1'b1; rsp_rdata = 32'h1111;
    @(negedge clk);
    check("unexp_before", 64'(err_unexp), 64'd0);
    next_cyc();
    rsp_valid = 1'b0;
    @(negedge clk);
    check("unexp_set", 64'(err_unexp), 64'd1);
    check("unexp_no_rvalid", 64'(s_rvalid), 64'd0);
    next_cyc();

    // Ports 0/1 read continuously; pointer starts at 3 so port 0 wins first
    set_ar(0, 32'h100); set_ar(1, 32'h200);
    clear_tv();
    for (int c = 0; c <= 6; c++) tv_arv[c] = 4'b0011;
    ex_ar[0] = 4'b0001; ex_ar[1] = 4'b0010; ex_ar[5] = 4'b0001; ex_ar[6] = 4'b0010;
    tv_rspv[3] = 1; tv_rspd[3] = 32'hAAAA_0000;
    tv_rspv[4] = 1; tv_rspd[4] = 32'hBBBB_1111;
    tv_rspv[8] = 1; tv_rspd[8] = 32'hCCCC_2222;
    tv_rspv[9] = 1; tv_rspd[9] = 32'hDDDD_3333;
    ex_rv[4]  = 4'b0001; ex_rd[4]  = 32'hAAAA_0000;
    ex_rv[5]  = 4'b0010; ex_rd[5]  = 32'hBBBB_1111;
    ex_rv[9]  = 4'b0001; ex_rd[9]  = 32'hCCCC_2222;
    ex_rv[10] = 4'b0010; ex_rd[10] = 32'hDDDD_3333;
    ex_ac[1] = 1; ex_addr[1] = 24'h40;
    ex_ac[2] = 1; ex_addr[2] = 24'h80;
    ex_ac[6] = 1; ex_addr[6] = 24'h40;
    ex_ac[7] = 1; ex_addr[7] = 24'h80;
    run_tv("alt", 12);

    // Out-of-range read on port 1
    set_ar(1, 32'h1000_0000);
    s_arvalid = 4'b0010;
    @(negedge clk);
    check("oor_arready", 64'(s_arready), 64'b0010);
    next_cyc();
    s_arvalid = '0;
    @(negedge clk);
    check("oor_no_req", 64'(req_valid), 64'd0);
    check("oor_rvalid", 64'(s_rvalid), 64'b0010);
    check("oor_rresp", 64'(s_rresp[3:2]), 64'b10);
    check("oor_rdata", 64'(s_rdata[63:32]), 64'd0);
    next_cyc();
    @(negedge clk);
    check("oor_rvalid_clear", 64'(s_rvalid), 64'd0);
    next_cyc();

    // Tag FIFO fill: four reads, then the fifth waits for a response
    set_ar(1, 32'h200); set_ar(2, 32'h300); set_ar(3, 32'h400);
    clear_tv();
    for (int c = 0; c <= 10; c++) tv_arv[c] = 4'b1111;
    ex_ar[0] = 4'b0100; ex_ar[1] = 4'b1000; ex_ar[2] = 4'b0001; ex_ar[3] = 4'b0010;
    ex_ar[10] = 4'b0100;
    tv_rspv[8]  = 1; tv_rspd[8]  = 32'h5555_0002;
    tv_rspv[12] = 1; tv_rspd[12] = 32'h6666_0003;
    tv_rspv[13] = 1; tv_rspd[13] = 32'h7777_0000;
    ex_rv[9]  = 4'b0100; ex_rd[9]  = 32'h5555_0002;
    ex_rv[13] = 4'b1000; ex_rd[13] = 32'h6666_0003;
    ex_rv[14] = 4'b0001; ex_rd[14] = 32'h7777_0000;
    ex_ac[1] = 1; ex_addr[1] = 24'hC0;
    run_tv("fill", 16);

    // Reset with two reads outstanding
    s_arvalid = 4'b0001; s_awvalid = 4'b0001; s_wvalid = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_req_valid", 64'(req_valid), 64'd0);
    check("mrst_arready", 64'(s_arready), 64'd0);
    check("mrst_awready", 64'(s_awready), 64'd0);
    check("mrst_rvalid", 64'(s_rvalid), 64'd0);
    check("mrst_bvalid", 64'(s_bvalid), 64'd0);
    check("mrst_err", 64'(err_unexp), 64'd0);
    check("mrst_rdata_lo", 64'(s_rdata[63:0]), 64'd0);
    check("mrst_rdata_hi", 64'(s_rdata[127:64]), 64'd0);
    check("mrst_rresp", 64'(s_rresp), 64'd0);
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
    next_cyc();
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 32'h0BAD;
    @(negedge clk);
    check("mrst_rsp_no_rvalid", 64'(s_rvalid), 64'd0);
    next_cyc();
    rsp_valid = 1'b0;
    @(negedge clk);
    check("mrst_err_set", 64'(err_unexp), 64'd1);
    check("mrst_rvalid_still0", 64'(s_rvalid), 64'd0);
    next_cyc();

    // Port 3 with write and read both pending: write first, then alternate
    set_wr(3, 32'h50, 32'h0BAD_F00D, 4'hF);
    set_ar(3, 32'h60);
    clear_tv();
    for (int c = 0; c <= 6; c++) begin
      tv_awv[c] = 4'b1000;
      tv_arv[c] = 4'b1000;
    end
    ex_aw[0] = 4'b1000; ex_ar[2] = 4'b1000; ex_aw[6] = 4'b1000;
    tv_rspv[4] = 1; tv_rspd[4] = 32'h9999_0003;
    ex_rv[5] = 4'b1000; ex_rd[5] = 32'h9999_0003;
    ex_ac[1] = 1; ex_addr[1] = 24'h14;
    ex_ac[3] = 1; ex_addr[3] = 24'h18;
    run_tv("tog", 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axil_sdram_arb.md
AXIL_SDRAM_ARB -- requirements
Module: axil_sdram_arb

Interface
REQ-001 SHALL have parameters: NPORTS, 2, AXI-lite slave port count (1..8).
REQ-002 SHALL have parameters: ADDR_WIDTH, 32, AXI byte address width.
REQ-003 SHALL have parameters: DATA_WIDTH, 32, data width (32 only).
REQ-004 SHALL have parameters: SDADDR_WIDTH, 24, SDRAM word address width.
REQ-005 SHALL have parameters: MAX_RD, 4, read-tag FIFO depth (power of 2, ≥2).
REQ-006 SHALL have ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_awaddr/s_araddr  in  NPORTS*ADDR_WIDTH  per-port addresses, port p at slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- s_awvalid/s_wvalid/s_arvalid/s_bready/s_rready  in  NPORTS  per-port handshakes.
- s_wdata  in  NPORTS*DATA_WIDTH  write data.
- s_wstrb  in  NPORTS*DATA_WIDTH/8  byte strobes.
- s_awready/s_wready/s_arready/s_bvalid/s_rvalid  out  NPORTS.
- s_bresp/s_rresp  out  NPORTS*2.
- s_rdata  out  NPORTS*DATA_WIDTH.
- req_valid  out  1;  req_ready  in  1;  req_we  out  1.
- req_addr  out  SDADDR_WIDTH  word address.
- req_wdata  out  DATA_WIDTH;  req_wmask  out  DATA_WIDTH/8  (active-high byte enables = wstrb).
- rsp_valid  in  1;  rsp_rdata  in  DATA_WIDTH  in-order read returns, no backpressure.
- err_unexp  out  1  sticky: rsp_valid seen with tag FIFO empty.

Function
REQ-007 SHALL define port p as eligible-write when awvalid&wvalid and no B/R pending on p; eligible-read when arvalid, no B/R pending, and tag count < MAX_RD.
REQ-008 SHALL grant one port per cycle, only when output slot free (!req_valid or req_ready), round-robin starting from port after last granted; pointer advances only on grant.
REQ-009 SHALL, within a port with both write and read eligible, alternate read/write using a per-port toggle, initial write.
REQ-010 SHALL assert awready and wready together (single-cycle pulse) on write grant; arready single-cycle pulse on read grant; never otherwise.
REQ-011 SHALL compute word address = axaddr[SDADDR_WIDTH+1:2]; axaddr[ADDR_WIDTH-1:SDADDR_WIDTH+2] nonzero SHALL be out-of-range.
REQ-012 SHALL, for an in-range grant at cycle T, drive req_valid=1 with req_we/addr/wdata/wmask from cycle T+1, held stable until req_ready.
REQ-013 SHALL, on write grant, assert s_bvalid[p] at T+1 with bresp=OKAY(00), held until bready.
REQ-014 SHALL, on read grant, push p into the tag FIFO at T; on rsp_valid pop tag, load rdata into port's R register, assert rvalid next cycle, rresp=OKAY, held until rready.
REQ-015 SHALL, on out-of-range grant, issue no request and push no tag; respond bresp/rresp=SLVERR(10) at T+1, rdata=0.
REQ-016 SHALL permit simultaneous tag push and pop in one cycle (count unchanged).
REQ-017 SHALL ignore rsp_valid with tag FIFO empty and set err_unexp=1 until reset.
REQ-018 SHALL allow at most one outstanding transaction per port; B or R pending blocks that port only.

Reset
REQ-019 SHALL, while rst_n=0, force all ready/valid outputs, req_*, s_bresp/s_rresp/s_rdata and err_unexp to 0, tag FIFO empty, RR pointer to port 0, toggles to write.
REQ-020 SHALL, on reset mid-operation, discard pending requests, tags and responses; later rsp_valid SHALL set err_unexp.

Verification
REQ-021 Port0 write addr 0x0000_0010 data 0xDEADBEEF strb 0xF, req_ready=1 -> req_valid cycle after awready, req_addr=0x4, req_we=1, bvalid+OKAY.
REQ-022 Both ports arvalid continuously, rsp after 3 cycles, rready=1 -> grants alternate 0,1,0,1; each rdata routed to the port that issued it.
REQ-023 NPORTS=4, MAX_RD=4, req_ready=1, rsp withheld -> exactly 4 read grants, 5th blocked until one rsp_valid.
REQ-024 Port1 araddr 0x1000_0000 (out of range, SDADDR_WIDTH=24) -> no req_valid, rvalid with rresp=10, rdata=0.
REQ-025 req_ready=0 for 5 cycles with pending write -> req_* stable, no further grants; rsp_valid with empty FIFO -> err_unexp=1.
REQ-026 rst_n low for 1 cycle with 2 reads outstanding -> all outputs 0; subsequent rsp_valid sets err_unexp, no rvalid.
